jtdd_sub_com: RTL and testbench

- Sub-CPU (MCU) end of the main-CPU/MCU communication interface in the Double Dragon core.
- Responds to the main CPU's control lines: NMI set, halt request and reset.
- Returns the bus-available flag (mcu_ban) and the IRQ-to-main (mcu_irqmain).
- Owns the shared 512-byte communication RAM that both CPUs access.

---
 rtl/jtdd_sub_com_pkg.sv | 14 +
 rtl/jtdd_sub_com_ram.sv | 29 ++
 rtl/jtdd_sub_com.sv | 153 +++++++++++++++
 tb/tb_jtdd_sub_com.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_sub_com_pkg.sv
// Shared definitions for the Double Dragon sub-CPU communication block:
// FSM state encoding and default shared-RAM address width.
package jtdd_sub_com_pkg;

    localparam int DEF_AW = 9;

    typedef enum logic [1:0] {
        ST_RESET    = 2'd0,
        ST_RUN      = 2'd1,
        ST_HALT_REQ = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

endpackage

// File: rtl/jtdd_sub_com_ram.sv
// True dual-port 2^AW x 8 shared RAM with one-clk synchronous reads.
// Same-address collisions: the main write wins; read-during-write returns old data.
module jtdd_sub_com_ram #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          main_we_i,
    input  logic [AW-1:0] main_addr_i,
    input  logic [7:0]    main_data_i,
    output logic [7:0]    main_q_o,
    input  logic          sub_we_i,
    input  logic [AW-1:0] sub_addr_i,
    input  logic [7:0]    sub_data_i,
    output logic [7:0]    sub_q_o
);

    logic [7:0] mem [2**AW];
    logic       sub_wr_ok;

    assign sub_wr_ok = sub_we_i && !(main_we_i && main_addr_i == sub_addr_i);

    always_ff @(posedge clk) begin
        if (main_we_i) mem[main_addr_i] <= main_data_i;
        if (sub_wr_ok) mem[sub_addr_i]  <= sub_data_i;
        main_q_o <= mem[main_addr_i];
        sub_q_o  <= mem[sub_addr_i];
    end

endmodule

// File: rtl/jtdd_sub_com.sv
// Sub-CPU end of the main/MCU link: reset/halt FSM, NMI latch, IRQ pulse, shared RAM.
// Optional forced halt grant after TIMEOUT clks: define JTDD_SUBHALT_TIMEOUT_EN.
import jtdd_sub_com_pkg::*;

module jtdd_sub_com #(
    parameter int AW        = DEF_AW,
    parameter int PULSE_LEN = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          main_cs_i,
    input  logic          main_we_i,
    input  logic [AW-1:0] main_addr_i,
    input  logic [7:0]    main_dout_i,
    output logic [7:0]    main_din_o,
    input  logic          mcu_nmi_set_i,
    input  logic          mcu_halt_i,
    input  logic          mcu_rstb_i,
    output logic          mcu_ban_o,
    output logic          mcu_irqmain_o,
    input  logic          sub_cs_i,
    input  logic          sub_we_i,
    input  logic [AW-1:0] sub_addr_i,
    input  logic [7:0]    sub_dout_i,
    output logic [7:0]    sub_din_o,
    input  logic          sub_ba_i,
    input  logic          sub_nmi_clr_i,
    input  logic          sub_irq_set_i,
    output logic          sub_nmi_o,
    output logic          sub_halt_o,
    output logic          sub_rst_o
);

    localparam int PW = $clog2(PULSE_LEN + 1);

    logic   halt_q, rstb_q, nmi_q, nmi_last_q, ba_q;
    state_e st_q, st_d;
    logic   nmi_lat_q, nmi_lat_d;
    logic   [PW-1:0] irq_cnt_q, irq_cnt_d;
    logic   tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q     <= 1'b0;
            rstb_q     <= 1'b0;
            nmi_q      <= 1'b0;
            nmi_last_q <= 1'b0;
            ba_q       <= 1'b0;
        end else begin
            halt_q     <= mcu_halt_i;
            rstb_q     <= mcu_rstb_i;
            nmi_q      <= mcu_nmi_set_i;
            nmi_last_q <= nmi_q;
            ba_q       <= sub_ba_i;
        end
    end

`ifdef JTDD_SUBHALT_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_flag_q;  // sticky, observable in simulation only

    assign tmo_hit = (st_q == ST_HALT_REQ) && (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (st_q == ST_HALT_REQ) ? tmo_cnt_q + TW'(1) : '0;
            if (st_q == ST_HALT_REQ && st_d == ST_HALTED && !ba_q) tmo_flag_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= ST_RESET;
        else     st_q <= st_d;
    end

    // A withdrawn halt request beats a late bus acknowledge.
    always_comb begin
        st_d       = st_q;
        sub_rst_o  = 1'b0;
        sub_halt_o = 1'b0;
        mcu_ban_o  = 1'b0;
        case (st_q)
            ST_RESET: begin
                sub_rst_o = 1'b1;
                mcu_ban_o = 1'b1;
                st_d      = halt_q ? ST_HALT_REQ : ST_RUN;
            end
            ST_RUN: begin
                if (halt_q) st_d = ST_HALT_REQ;
            end
            ST_HALT_REQ: begin
                sub_halt_o = 1'b1;
                if (!halt_q)           st_d = ST_RUN;
                else if (ba_q || tmo_hit) st_d = ST_HALTED;
            end
            ST_HALTED: begin
                sub_halt_o = 1'b1;
                mcu_ban_o  = 1'b1;
                if (!halt_q) st_d = ST_RUN;
            end
            default: st_d = ST_RESET;
        endcase
        if (!rstb_q) st_d = ST_RESET;
    end

    always_comb begin
        nmi_lat_d = nmi_lat_q;
        if (st_q == ST_RESET)          nmi_lat_d = 1'b0;
        else if (nmi_q && !nmi_last_q) nmi_lat_d = 1'b1;
        else if (sub_nmi_clr_i)        nmi_lat_d = 1'b0;
    end

    always_comb begin
        irq_cnt_d = irq_cnt_q;
        if (sub_irq_set_i && st_q != ST_RESET) irq_cnt_d = PW'(PULSE_LEN);
        else if (irq_cnt_q != '0)              irq_cnt_d = irq_cnt_q - PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_lat_q <= 1'b0;
            irq_cnt_q <= '0;
        end else begin
            nmi_lat_q <= nmi_lat_d;
            irq_cnt_q <= irq_cnt_d;
        end
    end

    assign sub_nmi_o     = nmi_lat_q && (st_q != ST_RESET);
    assign mcu_irqmain_o = (irq_cnt_q != '0);

    jtdd_sub_com_ram #(.AW(AW)) u_ram (
        .clk         (clk),
        .main_we_i   (main_cs_i && main_we_i),
        .main_addr_i (main_addr_i),
        .main_data_i (main_dout_i),
        .main_q_o    (main_din_o),
        .sub_we_i    (sub_cs_i && sub_we_i),
        .sub_addr_i  (sub_addr_i),
        .sub_data_i  (sub_dout_i),
        .sub_q_o     (sub_din_o)
    );

endmodule

// File: tb/tb_jtdd_sub_com.sv
// Bench for jtdd_sub_com: per-cycle behavioural model plus directed literal checks
// and a randomized phase. Define JTDD_SUBHALT_TIMEOUT_EN to also check the halt timeout.
module tb_jtdd_sub_com;

    localparam int AW = 9, PULSE_LEN = 4, TIMEOUT = 1024;
`ifdef JTDD_SUBHALT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int M_OFF = 0, M_GO = 1, M_ASK = 2, M_PARKED = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic main_cs, main_we, sub_cs, sub_we;
    logic [AW-1:0] main_addr, sub_addr;
    logic [7:0] main_dout, sub_dout, main_din, sub_din;
    logic nmi_set, halt, rstb, ban, irqmain, ba, nmi_clr, irq_set;
    logic sub_nmi, sub_halt, sub_rst;

    always #5 clk = ~clk;

    jtdd_sub_com dut (
        .clk(clk), .rst(rst),
        .main_cs_i(main_cs), .main_we_i(main_we), .main_addr_i(main_addr),
        .main_dout_i(main_dout), .main_din_o(main_din),
        .mcu_nmi_set_i(nmi_set), .mcu_halt_i(halt), .mcu_rstb_i(rstb),
        .mcu_ban_o(ban), .mcu_irqmain_o(irqmain),
        .sub_cs_i(sub_cs), .sub_we_i(sub_we), .sub_addr_i(sub_addr),
        .sub_dout_i(sub_dout), .sub_din_o(sub_din),
        .sub_ba_i(ba), .sub_nmi_clr_i(nmi_clr), .sub_irq_set_i(irq_set),
        .sub_nmi_o(sub_nmi), .sub_halt_o(sub_halt), .sub_rst_o(sub_rst)
    );

    int errs = 0, checks = 0;

    // model: mode, what the block has "seen" of each input (one clk old), NMI flag,
    // remaining IRQ clks, clks spent waiting for the bus, RAM contents
    int mode = M_OFF, irq_left = 0, waited = 0;
    bit s_halt, s_rstb, s_nmi, s_nmi_old, s_ba, flag;
    logic [7:0] mem [2**AW];
    logic [7:0] x_main = 8'hxx, x_sub = 8'hxx;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int nm;
        x_main = mem[main_addr];
        x_sub  = mem[sub_addr];
        if (sub_cs && sub_we)   mem[sub_addr]  = sub_dout;
        if (main_cs && main_we) mem[main_addr] = main_dout;
        if (rst) begin
            mode = M_OFF; irq_left = 0; waited = 0; flag = 0;
            {s_halt, s_rstb, s_nmi, s_nmi_old, s_ba} = '0;
            return;
        end
        nm = mode;
        if (!s_rstb) nm = M_OFF;
        else if (mode == M_OFF) nm = s_halt ? M_ASK : M_GO;
        else if (mode == M_GO) begin if (s_halt) nm = M_ASK; end
        else if (mode == M_ASK) begin
            if (!s_halt) nm = M_GO;
            else if (s_ba || (TMO_EN && waited + 1 == TIMEOUT)) nm = M_PARKED;
        end
        else if (!s_halt) nm = M_GO;
        waited = (mode == M_ASK) ? waited + 1 : 0;
        if (mode == M_OFF) flag = 0;
        else if (s_nmi && !s_nmi_old) flag = 1;
        else if (nmi_clr) flag = 0;
        if (irq_set && mode != M_OFF) irq_left = PULSE_LEN;
        else if (irq_left > 0) irq_left--;
        mode = nm;
        s_nmi_old = s_nmi;
        s_halt = halt; s_rstb = rstb; s_nmi = nmi_set; s_ba = ba;
    endtask

    task automatic compare();
        chk("m_sub_rst", sub_rst, int'(mode == M_OFF));
        chk("m_sub_halt", sub_halt, int'(mode == M_ASK || mode == M_PARKED));
        chk("m_ban", ban, int'(mode == M_OFF || mode == M_PARKED));
        chk("m_sub_nmi", sub_nmi, int'(flag && mode != M_OFF));
        chk("m_irqmain", irqmain, int'(irq_left > 0));
        if (!$isunknown(x_main)) chk("m_main_din", main_din, x_main);
        if (!$isunknown(x_sub))  chk("m_sub_din", sub_din, x_sub);
    endtask

    // one clk: model follows the edge, outputs checked shortly after, returns at negedge
    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #2 compare();
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        {main_cs, main_we, sub_cs, sub_we, nmi_set, halt, rstb, ba, nmi_clr, irq_set} = '0;
        main_addr = '0; sub_addr = '0; main_dout = '0; sub_dout = '0;
        cycle(2);
        rst = 1'b0;
        cycle();
        chk("rst_sub_rst", sub_rst, 1);
        chk("rst_ban", ban, 1);
        chk("rst_halt", sub_halt, 0);
        chk("rst_nmi", sub_nmi, 0);
        chk("rst_irq", irqmain, 0);

        // reset release
        rstb = 1; cycle();
        chk("rel1_sub_rst", sub_rst, 1);
        cycle();
        chk("rel2_sub_rst", sub_rst, 0);
        chk("rel2_ban", ban, 0);

        // halt handshake
        halt = 1; cycle();
        chk("hreq1_halt", sub_halt, 0);
        cycle();
        chk("hreq2_halt", sub_halt, 1);
        chk("hreq2_ban", ban, 0);
        ba = 1; cycle(2);
        chk("halted_ban", ban, 1);
        halt = 0; cycle();
        chk("unhalt1_halt", sub_halt, 1);
        cycle();
        chk("unhalt2_halt", sub_halt, 0);
        chk("unhalt2_ban", ban, 0);
        ba = 0; cycle();

        // NMI: set, set beating clear, lone clear
        nmi_set = 1; cycle(2);
        chk("nmi_set", sub_nmi, 1);
        nmi_set = 0; cycle();
        nmi_set = 1; cycle();
        nmi_clr = 1; cycle();
        nmi_clr = 0;
        chk("nmi_setwins", sub_nmi, 1);
        nmi_set = 0; cycle();
        nmi_clr = 1; cycle();
        nmi_clr = 0;
        chk("nmi_clr", sub_nmi, 0);

        // IRQ pulse length, single and retriggered
        n = 0;
        for (int i = 0; i < 10; i++) begin
            irq_set = (i == 0); cycle();
            if (irqmain) n++;
        end
        chk("irq_len1", n, 4);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            irq_set = (i == 0 || i == 2); cycle();
            if (irqmain) n++;
        end
        chk("irq_len2", n, 6);

        // RAM collision and cross-port read
        main_cs = 1; main_we = 1; main_addr = 9'h1FF; main_dout = 8'hA5;
        sub_cs = 1;  sub_we = 1;  sub_addr = 9'h1FF;  sub_dout = 8'h3C;
        cycle();
        main_we = 0; sub_we = 0; cycle();
        chk("col_main", main_din, 8'hA5);
        chk("col_sub", sub_din, 8'hA5);
        sub_we = 1; sub_addr = 9'h010; sub_dout = 8'h77; cycle();
        sub_we = 0; main_addr = 9'h010; cycle();
        chk("x_main_rd", main_din, 8'h77);

        // reset while halted
        nmi_set = 1; halt = 1; ba = 1; cycle(4);
        chk("mid_ban", ban, 1);
        chk("mid_nmi", sub_nmi, 1);
        rstb = 0; cycle();
        chk("mid1_ban", ban, 1);
        cycle();
        chk("mid2_rst", sub_rst, 1);
        chk("mid2_nmi", sub_nmi, 0);
        chk("mid2_ban", ban, 1);
        rstb = 1; halt = 0; ba = 0; nmi_set = 0; cycle(3);

`ifdef JTDD_SUBHALT_TIMEOUT_EN
        n = 0;
        halt = 1;
        for (int i = 0; i < 1200 && !ban; i++) begin
            cycle();
            if (sub_halt && !ban) n++;
        end
        chk("tmo_wait", n, TIMEOUT);
        chk("tmo_ban", ban, 1);
        halt = 0; cycle(3);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int a;
            rst     = ($urandom_range(0, 599) == 0);
            rstb    = ($urandom_range(0, 99) >= 3);
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            if ($urandom_range(0, 3) == 0)  ba = ~ba;
            if ($urandom_range(0, 3) == 0)  nmi_set = ~nmi_set;
            nmi_clr = ($urandom_range(0, 5) == 0);
            irq_set = ($urandom_range(0, 7) == 0);
            main_cs = ($urandom_range(0, 9) < 7);
            main_we = $urandom_range(0, 1);
            sub_cs  = ($urandom_range(0, 9) < 7);
            sub_we  = $urandom_range(0, 1);
            a = $urandom_range(0, 4); main_addr = (a == 4) ? 9'h1FF : AW'(a);
            a = $urandom_range(0, 4); sub_addr  = (a == 4) ? 9'h1FF : AW'(a);
            main_dout = 8'($urandom);
            sub_dout  = 8'($urandom);
            cycle();
        end
        rst = 0;
        cycle(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
